bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 24 ++
 rtl/arb_bus_mux.sv | 63 ++++++
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and widths for the two-master bus arbiter.
package bus_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STYPE_W = 2;
  localparam int LTYPE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  // One-hot grant vector for a given owner state; 2'b00 when idle.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      OWN_M0:  grant_of = 2'b01;
      OWN_M1:  grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/arb_bus_mux.sv
// Combinational steering between the two masters and the bus, selected by the one-hot grant.
module arb_bus_mux
  import bus_pkg::*;
(
  input  logic [1:0]         grant,
  input  logic               m0_req,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [DATA_W-1:0]  m0_wdata,
  input  logic               m0_wr_en,
  input  logic [STYPE_W-1:0] m0_storeType,
  input  logic [LTYPE_W-1:0] m0_loadType,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_ready,
  input  logic               m1_req,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [DATA_W-1:0]  m1_wdata,
  input  logic               m1_wr_en,
  input  logic [STYPE_W-1:0] m1_storeType,
  input  logic [LTYPE_W-1:0] m1_loadType,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_ready,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  output logic               bus_wr_en,
  output logic [STYPE_W-1:0] bus_storeType,
  output logic [LTYPE_W-1:0] bus_loadType,
  input  logic [DATA_W-1:0]  bus_rdata
);

  always_comb begin
    bus_addr      = '0;
    bus_wdata     = '0;
    bus_wr_en     = 1'b0;
    bus_storeType = '0;
    bus_loadType  = '0;
    m0_rdata      = '0;
    m1_rdata      = '0;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;
    case (grant)
      2'b01: begin
        bus_addr      = m0_addr;
        bus_wdata     = m0_wdata;
        bus_wr_en     = m0_wr_en & m0_req;
        bus_storeType = m0_storeType;
        bus_loadType  = m0_loadType;
        m0_rdata      = bus_rdata;
        m0_ready      = m0_req;
      end
      2'b10: begin
        bus_addr      = m1_addr;
        bus_wdata     = m1_wdata;
        bus_wr_en     = m1_wr_en & m1_req;
        bus_storeType = m1_storeType;
        bus_loadType  = m1_loadType;
        m1_rdata      = bus_rdata;
        m1_ready      = m1_req;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a bounded hold time before forced handover.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_req,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [DATA_W-1:0]  m0_wdata,
  input  logic               m0_wr_en,
  input  logic [STYPE_W-1:0] m0_storeType,
  input  logic [LTYPE_W-1:0] m0_loadType,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_ready,
  input  logic               m1_req,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [DATA_W-1:0]  m1_wdata,
  input  logic               m1_wr_en,
  input  logic [STYPE_W-1:0] m1_storeType,
  input  logic [LTYPE_W-1:0] m1_loadType,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_ready,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  output logic               bus_wr_en,
  output logic [STYPE_W-1:0] bus_storeType,
  output logic [LTYPE_W-1:0] bus_loadType,
  input  logic [DATA_W-1:0]  bus_rdata,
  output logic [1:0]         grant
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             last_m1;
  logic             beat;
  logic             hold_done;

  assign beat      = (state == OWN_M0 && m0_req) || (state == OWN_M1 && m1_req);
  assign hold_done = (hold_cnt == HOLD_LAST);

  // Owner keeps the bus while requesting unless its hold budget is spent and the peer waits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last_m1 ? OWN_M0 : OWN_M1;
        else if (m0_req)      state_nxt = OWN_M0;
        else if (m1_req)      state_nxt = OWN_M1;
      end
      OWN_M0: begin
        if (!m0_req)                  state_nxt = m1_req ? OWN_M1 : IDLE;
        else if (hold_done && m1_req) state_nxt = OWN_M1;
      end
      OWN_M1: begin
        if (!m1_req)                  state_nxt = m0_req ? OWN_M0 : IDLE;
        else if (hold_done && m0_req) state_nxt = OWN_M0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 2'b00;
      hold_cnt <= '0;
      last_m1  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_of(state_nxt);
      if (state_nxt != state)
        hold_cnt <= '0;
      else if (beat && !hold_done)
        hold_cnt <= hold_cnt + CNT_W'(1);
      if (state_nxt != state && state_nxt == OWN_M0) last_m1 <= 1'b0;
      if (state_nxt != state && state_nxt == OWN_M1) last_m1 <= 1'b1;
    end
  end

  arb_bus_mux u_mux (
    .grant         (grant),
    .m0_req        (m0_req),
    .m0_addr       (m0_addr),
    .m0_wdata      (m0_wdata),
    .m0_wr_en      (m0_wr_en),
    .m0_storeType  (m0_storeType),
    .m0_loadType   (m0_loadType),
    .m0_rdata      (m0_rdata),
    .m0_ready      (m0_ready),
    .m1_req        (m1_req),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_wr_en      (m1_wr_en),
    .m1_storeType  (m1_storeType),
    .m1_loadType   (m1_loadType),
    .m1_rdata      (m1_rdata),
    .m1_ready      (m1_ready),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wr_en     (bus_wr_en),
    .bus_storeType (bus_storeType),
    .bus_loadType  (bus_loadType),
    .bus_rdata     (bus_rdata)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter with hand-computed expectations.
module tb_bus_arbiter;

  logic        clk, reset;
  logic        m0_req, m0_wr_en, m1_req, m1_wr_en;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_storeType, m1_storeType, bus_storeType;
  logic [2:0]  m0_loadType, m1_loadType, bus_loadType;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        m0_ready, m1_ready, bus_wr_en;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr_en(m0_wr_en),
    .m0_storeType(m0_storeType), .m0_loadType(m0_loadType),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr_en(m1_wr_en),
    .m1_storeType(m1_storeType), .m1_loadType(m1_loadType),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr_en(bus_wr_en),
    .bus_storeType(bus_storeType), .bus_loadType(bus_loadType),
    .bus_rdata(bus_rdata), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int rdy_cnt;
  int grant_cnt;

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_wr_en = 0; m0_addr = 0; m0_wdata = 0; m0_storeType = 0; m0_loadType = 0;
    m1_req = 0; m1_wr_en = 0; m1_addr = 0; m1_wdata = 0; m1_storeType = 0; m1_loadType = 0;
    bus_rdata = 32'h1234_5678;
    step(); step();
    chk("rst_grant", {30'd0, grant}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wr_en", {31'd0, bus_wr_en}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'h0);
    reset = 1'b0;

    // Single write from M0
    m0_req = 1; m0_wr_en = 1; m0_addr = 32'h10; m0_wdata = 32'hA5;
    m0_storeType = 2'd2; m0_loadType = 3'd5;
    #1;
    chk("t1_idle_grant", {30'd0, grant}, 32'h0);
    chk("t1_idle_ready", {31'd0, m0_ready}, 32'h0);
    step();
    chk("t1_grant", {30'd0, grant}, 32'h1);
    chk("t1_m0_ready", {31'd0, m0_ready}, 32'h1);
    chk("t1_bus_wr_en", {31'd0, bus_wr_en}, 32'h1);
    chk("t1_bus_addr", bus_addr, 32'h10);
    chk("t1_bus_wdata", bus_wdata, 32'hA5);
    chk("t1_bus_stype", {30'd0, bus_storeType}, 32'h2);
    chk("t1_bus_ltype", {29'd0, bus_loadType}, 32'h5);
    chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_m1_ready", {31'd0, m1_ready}, 32'h0);
    m0_req = 0; m0_wr_en = 0;
    #1;
    chk("t1_drop_ready", {31'd0, m0_ready}, 32'h0);
    chk("t1_drop_wr_en", {31'd0, bus_wr_en}, 32'h0);
    step();
    chk("t1_idle_after", {30'd0, grant}, 32'h0);

    // Tie from IDLE after reset: M0 first, then handover without bubble
    reset = 1; #1; reset = 0;
    m0_req = 1; m1_req = 1;
    step();
    chk("t2_grant_m0", {30'd0, grant}, 32'h1);
    chk("t2_m0_ready", {31'd0, m0_ready}, 32'h1);
    chk("t2_m1_ready", {31'd0, m1_ready}, 32'h0);
    m0_req = 0;
    #1;
    chk("t2_no_bubble", {30'd0, grant}, 32'h1);
    step();
    chk("t2_grant_m1", {30'd0, grant}, 32'h2);
    chk("t2_m1_ready", {31'd0, m1_ready}, 32'h1);
    m1_req = 0;
    step();
    chk("t2_idle", {30'd0, grant}, 32'h0);

    // Hold expiry with M1 waiting (last grant was M1, so M0 wins the tie)
    m0_req = 1; m1_req = 1;
    step();
    chk("t3_grant_m0", {30'd0, grant}, 32'h1);
    rdy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (grant != 2'b01) break;
      if (m0_ready) rdy_cnt++;
      if (m1_ready) rdy_cnt += 100;
      step();
    end
    chk("t3_ready_cycles", rdy_cnt, 32'd16);
    chk("t3_grant_m1", {30'd0, grant}, 32'h2);
    chk("t3_m1_ready", {31'd0, m1_ready}, 32'h1);
    chk("t3_m0_ready", {31'd0, m0_ready}, 32'h0);
    m0_req = 0; m1_req = 0;
    step();
    chk("t3_idle", {30'd0, grant}, 32'h0);

    // M0 alone for 20 beats keeps the bus
    m0_req = 1;
    step();
    rdy_cnt = 0; grant_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (m0_ready) rdy_cnt++;
      if (grant == 2'b01) grant_cnt++;
      if (i < 19) step();
    end
    chk("t4_ready_cycles", rdy_cnt, 32'd20);
    chk("t4_grant_cycles", grant_cnt, 32'd20);
    m0_req = 0;
    #1;
    chk("t4_still_owner", {30'd0, grant}, 32'h1);
    step();
    chk("t4_idle", {30'd0, grant}, 32'h0);

    // M1 owns, read data routing and non-owner isolation
    m1_req = 1; m1_addr = 32'h44; bus_rdata = 32'hDEADBEEF;
    step();
    m0_req = 1; m0_wr_en = 1;
    #1;
    chk("t5_grant", {30'd0, grant}, 32'h2);
    chk("t5_m1_rdata", m1_rdata, 32'hDEADBEEF);
    chk("t5_m0_rdata", m0_rdata, 32'h0);
    chk("t5_m0_ready", {31'd0, m0_ready}, 32'h0);
    chk("t5_bus_wr_en", {31'd0, bus_wr_en}, 32'h0);
    chk("t5_bus_addr", bus_addr, 32'h44);

    // Reset mid-write
    m0_req = 0; m0_wr_en = 0;
    m1_wr_en = 1;
    #1;
    chk("t6_wr_before", {31'd0, bus_wr_en}, 32'h1);
    reset = 1;
    #1;
    chk("t6_wr_en_async", {31'd0, bus_wr_en}, 32'h0);
    chk("t6_grant_async", {30'd0, grant}, 32'h0);
    chk("t6_m1_rdata", m1_rdata, 32'h0);
    chk("t6_m1_ready", {31'd0, m1_ready}, 32'h0);
    step();
    chk("t6_idle_held", {30'd0, grant}, 32'h0);
    m1_req = 0; m1_wr_en = 0; m0_req = 1;
    reset = 0;
    #1;
    chk("t6_idle_after", {30'd0, grant}, 32'h0);
    step();
    chk("t6_resume", {30'd0, grant}, 32'h1);
    m0_req = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
